// File: rtl/microwire_id_prom.sv
// Purpose : Microwire serial-EEPROM slave holding the board ID, clocked from CLK with synchronised CS/SK/DI.
// Latency : DO/DO_OE update 3 CLK after an SK rise or CS fall; a committed WRITE/ERASE holds BUSY for WRITE_CYCLES CLK.
// Backpressure: none on the serial side; frames arriving during the busy period are ignored and DO reports ready/busy.
// Ports   : CLK, RST_N (async active-low); CS/SK/DI/PE/PRE serial inputs; DO/DO_OE serial output and its
//           drive enable (tristate formed at top level); BUSY high while a write/erase is in progress.
// Option  : define MICROWIRE_PROTECT_EN to add the PRE-addressed protect register (writes at/above it blocked).
module microwire_id_prom #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 4,
  parameter logic [DATA_W-1:0] INIT_ID      = 16'hA5C3,
  parameter int                WRITE_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CS,
  input  logic SK,
  input  logic DI,
  input  logic PE,
  input  logic PRE,
  output logic DO,
  output logic DO_OE,
  output logic BUSY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = $clog2((DATA_W > ADDR_W) ? DATA_W : ADDR_W);
  localparam int BCW   = $clog2(WRITE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_OPC, S_ADDR, S_RDATA, S_WDATA, S_WAIT_CS, S_BUSY
  } state_t;

  logic [1:0] cs_sync, sk_sync, di_sync;
  logic       sk_prev;
  logic       cs_s, di_s, sk_rise;

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [BCW-1:0]      bcnt_q, bcnt_n;
  logic [1:0]          opc_q, opc_n;
  logic [ADDR_W-1:0]   addr_q, addr_n, addr_shift, addr_inc;
  logic [DATA_W-1:0]   sr_q, sr_n;
  logic                wen_q, wen_n, do_q, do_n, oe_q, oe_n, busy_q, busy_n;
  logic                mem_we, commit_ok;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MICROWIRE_PROTECT_EN
  logic                pre_q, pre_n;
  logic [ADDR_W-1:0]   prot_q, prot_n;
`else
  logic                unused_pre;
  assign unused_pre = PRE;
`endif

  assign cs_s       = cs_sync[1];
  assign di_s       = di_sync[1];
  assign sk_rise    = sk_sync[1] & ~sk_prev;
  assign addr_shift = {addr_q[ADDR_W-2:0], di_s};
  assign addr_inc   = addr_q + ADDR_W'(1);

`ifdef MICROWIRE_PROTECT_EN
  // PRE frames only ever write the protect register; normal frames must stay below it.
  assign commit_ok = wen_q && PE &&
                     (pre_q ? (opc_q == 2'b01)
                            : (((opc_q == 2'b01) || (opc_q == 2'b11)) && (addr_q < prot_q)));
`else
  assign commit_ok = wen_q && PE && ((opc_q == 2'b01) || (opc_q == 2'b11));
`endif

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    bcnt_n    = bcnt_q;
    opc_n     = opc_q;
    addr_n    = addr_q;
    sr_n      = sr_q;
    wen_n     = wen_q;
    do_n      = do_q;
    oe_n      = oe_q;
    busy_n    = busy_q;
    mem_we    = 1'b0;
    mem_wdata = sr_q;
`ifdef MICROWIRE_PROTECT_EN
    pre_n     = pre_q;
    prot_n    = prot_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        do_n = 1'b0;
        oe_n = 1'b0;
        if (cs_s) state_n = S_START;
      end
      S_START, S_OPC, S_ADDR, S_RDATA, S_WDATA: begin
        if (!cs_s) begin
          // Abort: an incomplete frame never touches memory.
          state_n = S_IDLE;
          do_n    = 1'b0;
          oe_n    = 1'b0;
        end else if (sk_rise) begin
          unique case (state_q)
            S_START: begin
              if (di_s) begin
                state_n = S_OPC;
                cnt_n   = '0;
              end
            end
            S_OPC: begin
              opc_n = {opc_q[0], di_s};
              cnt_n = cnt_q + CW'(1);
              if (cnt_q == CW'(1)) begin
                state_n = S_ADDR;
                cnt_n   = '0;
              end
            end
            S_ADDR: begin
              addr_n = addr_shift;
              cnt_n  = cnt_q + CW'(1);
              if (cnt_q == CW'(ADDR_W - 1)) begin
                cnt_n = '0;
`ifdef MICROWIRE_PROTECT_EN
                pre_n = PRE;
`endif
                unique case (opc_q)
                  2'b10: begin
                    // Dummy zero goes out on this same edge; data follows from the next one.
                    oe_n    = 1'b1;
                    do_n    = 1'b0;
                    sr_n    = mem[addr_shift];
`ifdef MICROWIRE_PROTECT_EN
                    if (PRE) sr_n = DATA_W'(prot_q);
`endif
                    state_n = S_RDATA;
                  end
                  2'b01: begin
                    state_n = S_WDATA;
`ifdef MICROWIRE_PROTECT_EN
                    if (PRE) state_n = S_WAIT_CS;  // protect write carries no data field
`endif
                  end
                  2'b11: state_n = S_WAIT_CS;
                  default: begin
                    if (addr_shift[ADDR_W-1 -: 2] == 2'b11)      wen_n = 1'b1;
                    else if (addr_shift[ADDR_W-1 -: 2] == 2'b00) wen_n = 1'b0;
                    state_n = S_WAIT_CS;
                  end
                endcase
              end
            end
            S_RDATA: begin
              do_n  = sr_q[DATA_W-1];
              sr_n  = sr_q << 1;
              cnt_n = cnt_q + CW'(1);
              if (cnt_q == CW'(DATA_W - 1)) begin
                // Bit 0 leaves now; preload the next word so the stream is seamless.
                cnt_n  = '0;
                addr_n = addr_inc;
                sr_n   = mem[addr_inc];
`ifdef MICROWIRE_PROTECT_EN
                if (pre_q) sr_n = DATA_W'(prot_q);
`endif
              end
            end
            default: begin  // S_WDATA
              sr_n  = {sr_q[DATA_W-2:0], di_s};
              cnt_n = cnt_q + CW'(1);
              if (cnt_q == CW'(DATA_W - 1)) begin
                cnt_n   = '0;
                state_n = S_WAIT_CS;
              end
            end
          endcase
        end
      end
      S_WAIT_CS: begin
        // SK edges are ignored here; only the CS fall matters.
        if (!cs_s) begin
          do_n    = 1'b0;
          oe_n    = 1'b0;
          state_n = S_IDLE;
          if (commit_ok) begin
            busy_n  = 1'b1;
            bcnt_n  = '0;
            state_n = S_BUSY;
`ifdef MICROWIRE_PROTECT_EN
            if (pre_q) prot_n = addr_q;
            else begin
              mem_we    = 1'b1;
              mem_wdata = (opc_q == 2'b11) ? '1 : sr_q;
            end
`else
            mem_we    = 1'b1;
            mem_wdata = (opc_q == 2'b11) ? '1 : sr_q;
`endif
          end
        end
      end
      default: begin  // S_BUSY
        oe_n   = cs_s;
        do_n   = 1'b0;
        bcnt_n = bcnt_q + BCW'(1);
        if (bcnt_q == BCW'(WRITE_CYCLES - 1)) begin
          busy_n  = 1'b0;
          bcnt_n  = '0;
          state_n = S_IDLE;
          if (cs_s) begin
            // Hold "ready" on DO until CS falls; READ opcode keeps WAIT_CS from committing again.
            do_n    = 1'b1;
            oe_n    = 1'b1;
            opc_n   = 2'b10;
            state_n = S_WAIT_CS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_sync <= '0;
      sk_sync <= '0;
      di_sync <= '0;
      sk_prev <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      opc_q   <= '0;
      addr_q  <= '0;
      sr_q    <= '0;
      wen_q   <= 1'b0;
      do_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MICROWIRE_PROTECT_EN
      pre_q   <= 1'b0;
      prot_q  <= ADDR_W'(DEPTH - 1);
`endif
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= '1;
      mem[DEPTH-1] <= INIT_ID;
    end else begin
      cs_sync <= {cs_sync[0], CS};
      sk_sync <= {sk_sync[0], SK};
      di_sync <= {di_sync[0], DI};
      sk_prev <= sk_sync[1];
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bcnt_q  <= bcnt_n;
      opc_q   <= opc_n;
      addr_q  <= addr_n;
      sr_q    <= sr_n;
      wen_q   <= wen_n;
      do_q    <= do_n;
      oe_q    <= oe_n;
      busy_q  <= busy_n;
`ifdef MICROWIRE_PROTECT_EN
      pre_q   <= pre_n;
      prot_q  <= prot_n;
`endif
      if (mem_we) mem[addr_q] <= mem_wdata;
    end
  end

  assign DO    = do_q;
  assign DO_OE = oe_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_microwire_id_prom.sv
module tb_microwire_id_prom;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CS = 1'b0, SK = 1'b0, DI = 1'b0, PE = 1'b0, PRE = 1'b0;
  logic DO, DO_OE, BUSY;

  int n_vec = 0;
  int n_bad = 0;

  microwire_id_prom dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .SK(SK), .DI(DI), .PE(PE), .PRE(PRE),
    .DO(DO), .DO_OE(DO_OE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [3:0]  addr;
    logic [15:0] exp;
  } rvec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One SK period of 16 CLK; DO is sampled late in the low phase.
  task automatic sk_bit(input logic b, output logic d);
    DI = b;
    repeat (4) @(negedge CLK);
    SK = 1'b1;
    repeat (8) @(negedge CLK);
    SK = 1'b0;
    repeat (4) @(negedge CLK);
    d = DO;
  endtask

  task automatic send(input logic [31:0] v, input int n, output logic d);
    d = 1'b0;
    for (int i = n - 1; i >= 0; i--) sk_bit(v[i], d);
  endtask

  task automatic cs_on();
    CS = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic end_frame(input string nm);
    CS = 1'b0;
    repeat (3) @(negedge CLK);
    chk({nm, "_oe_off"}, {31'b0, DO_OE}, 32'd0);
    repeat (4) @(negedge CLK);
  endtask

  task automatic do_read(input logic [3:0] addr, input int lead, input int nw,
                         input logic [47:0] exp, input string nm);
    logic d;
    logic [15:0] word;
    cs_on();
    for (int i = 0; i < lead; i++) sk_bit(1'b0, d);
    send({25'b0, 3'b110, addr}, 7, d);
    chk({nm, "_dummy"}, {31'b0, d}, 32'd0);
    chk({nm, "_oe"}, {31'b0, DO_OE}, 32'd1);
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int b = 0; b < 16; b++) begin
        sk_bit(1'b0, d);
        word = {word[14:0], d};
      end
      chk($sformatf("%s_w%0d", nm, w), {16'b0, word}, {16'b0, exp[47-16*w -: 16]});
    end
    end_frame(nm);
  endtask

  // WRITE frame; ndata < 16 leaves it partial. CS is left high.
  task automatic write_frame(input logic [3:0] addr, input logic [15:0] data, input int ndata);
    logic d;
    cs_on();
    send({25'b0, 3'b101, addr}, 7, d);
    for (int i = 0; i < ndata; i++) sk_bit(data[15-i], d);
  endtask

  task automatic cmd_frame(input logic [6:0] bits);
    logic d;
    cs_on();
    send({25'b0, bits}, 7, d);
  endtask

  // Drops CS and checks whether a busy period of 64 CLK follows; optional status poll.
  task automatic finish_write(input logic exp_busy, input logic poll, input string nm);
    int i;
    int cnt;
    CS = 1'b0;
    i = 0;
    while (!BUSY && i < 10) begin
      @(negedge CLK);
      i++;
    end
    if (!exp_busy) begin
      chk({nm, "_no_busy"}, {31'b0, BUSY}, 32'd0);
      repeat (4) @(negedge CLK);
    end else begin
      chk({nm, "_busy_start"}, {31'b0, BUSY}, 32'd1);
      cnt = 0;
      while (BUSY && cnt < 200) begin
        cnt++;
        if (poll && cnt == 1) CS = 1'b1;
        if (poll && cnt == 10) begin
          chk({nm, "_stat_oe"}, {31'b0, DO_OE}, 32'd1);
          chk({nm, "_stat_busy"}, {31'b0, DO}, 32'd0);
        end
        @(negedge CLK);
      end
      chk({nm, "_busy_len"}, cnt, 32'd64);
      if (poll) begin
        chk({nm, "_stat_ready"}, {31'b0, DO}, 32'd1);
        repeat (20) @(negedge CLK);
        chk({nm, "_ready_hold"}, {31'b0, DO}, 32'd1);
        end_frame(nm);
      end else begin
        repeat (4) @(negedge CLK);
      end
    end
  endtask

  initial begin
    rvec_t tbl[4];
    tbl[0] = '{"rst_w0",  4'd0,  16'hFFFF};
    tbl[1] = '{"rst_w7",  4'd7,  16'hFFFF};
    tbl[2] = '{"rst_w14", 4'd14, 16'hFFFF};
    tbl[3] = '{"rst_w15", 4'd15, 16'hA5C3};

    repeat (3) @(negedge CLK);
    chk("rst_do", {31'b0, DO}, 32'd0);
    chk("rst_oe", {31'b0, DO_OE}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Reset contents
    for (int i = 0; i < 4; i++) do_read(tbl[i].addr, 0, 1, {tbl[i].exp, 32'h0}, tbl[i].nm);

    // READ with leading zeros
    do_read(4'd15, 2, 1, {16'hA5C3, 32'h0}, "t1_lead");

    // Sequential read across the wrap
    do_read(4'd14, 0, 3, {16'hFFFF, 16'hA5C3, 16'hFFFF}, "t2_wrap");

    // WRITE gating
    PE = 1'b1;
    write_frame(4'd3, 16'h1234, 16);
    finish_write(1'b0, 1'b0, "t3_nowen");
    do_read(4'd3, 0, 1, {16'hFFFF, 32'h0}, "t3_rd_nowen");
    cmd_frame(7'b1001100);  // EWEN
    end_frame("t3_ewen");
    write_frame(4'd3, 16'h1234, 16);
    repeat (30) @(negedge CLK);  // extra wait in WAIT_CS, SK idle
    finish_write(1'b1, 1'b1, "t3_wr");
    do_read(4'd3, 0, 1, {16'h1234, 32'h0}, "t3_rd");

    // Partial write aborts; then ERASE
    write_frame(4'd3, 16'h0F0F, 9);
    finish_write(1'b0, 1'b0, "t4_part");
    do_read(4'd3, 0, 1, {16'h1234, 32'h0}, "t4_rd_part");
    cmd_frame(7'b1110011);  // ERASE addr 3
    finish_write(1'b1, 1'b0, "t4_erase");
    do_read(4'd3, 0, 1, {16'hFFFF, 32'h0}, "t4_rd_erase");

    // Reset during busy
    write_frame(4'd5, 16'h5555, 16);
    CS = 1'b0;
    for (int i = 0; i < 10 && !BUSY; i++) @(negedge CLK);
    chk("t5_busy_start", {31'b0, BUSY}, 32'd1);
    repeat (10) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("t5_busy_rst", {31'b0, BUSY}, 32'd0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    do_read(4'd5, 0, 1, {16'hFFFF, 32'h0}, "t5_rd5");
    do_read(4'd15, 0, 1, {16'hA5C3, 32'h0}, "t5_rd15");
    write_frame(4'd5, 16'h0000, 16);
    finish_write(1'b0, 1'b0, "t5_wen_clr");
    do_read(4'd5, 0, 1, {16'hFFFF, 32'h0}, "t5_rd5b");

    // EWDS blocks a write that EWEN had allowed
    cmd_frame(7'b1001100);
    end_frame("ewen2");
    cmd_frame(7'b1000000);  // EWDS
    end_frame("ewds");
    write_frame(4'd6, 16'h6666, 16);
    finish_write(1'b0, 1'b0, "ewds_wr");
    do_read(4'd6, 0, 1, {16'hFFFF, 32'h0}, "ewds_rd");

`ifdef MICROWIRE_PROTECT_EN
    cmd_frame(7'b1001100);
    end_frame("t6_ewen");
    write_frame(4'd15, 16'h0000, 16);
    finish_write(1'b0, 1'b0, "t6_wr15");
    do_read(4'd15, 0, 1, {16'hA5C3, 32'h0}, "t6_rd15");
    PRE = 1'b1;
    write_frame(4'd8, 16'h0000, 0);
    finish_write(1'b1, 1'b0, "t6_prot");
    do_read(4'd0, 0, 1, {16'h0008, 32'h0}, "t6_rdprot");
    PRE = 1'b0;
    write_frame(4'd9, 16'h9999, 16);
    finish_write(1'b0, 1'b0, "t6_wr9");
    do_read(4'd9, 0, 1, {16'hFFFF, 32'h0}, "t6_rd9");
    write_frame(4'd7, 16'h7777, 16);
    finish_write(1'b1, 1'b0, "t6_wr7");
    do_read(4'd7, 0, 1, {16'h7777, 32'h0}, "t6_rd7");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/microwire_id_prom.md
Name: microwire_id_prom

Overview:
Synthesizable, parametrised Microwire serial-EEPROM slave for board identification, clocked from the system clock. Replaces the fixed 16x16 read-only behavioural model on the FEC/TUB boards. Supports sequential READ with address wrap, EWEN/EWDS write gating, WRITE and ERASE with a modelled busy time, and ready/busy status on DO. A host controller or a bench drives it over CS/SK/DI/DO.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 4, address bits per frame; depth = 2**ADDR_W words
INIT_ID, 16'hA5C3, reset contents of the top word (DEPTH-1), the board ID
WRITE_CYCLES, 64, CLK cycles of busy after a committed WRITE/ERASE

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST_N  in  1  asynchronous active-low reset
CS  in  1  chip select, active high, asynchronous to CLK
SK  in  1  serial clock, data sampled on SK rising edge; SK period >= 8 CLK
DI  in  1  serial data in
PE  in  1  program enable; WRITE/ERASE execute only if high at CS fall
PRE  in  1  protect-register select (used only with the optional feature)
DO  out  1  serial data / ready-busy status
DO_OE  out  1  DO drive enable; the top level forms the tristate
BUSY  out  1  high during the write/erase busy period

Behaviour:
- CS, SK, DI pass through 2-flop synchronisers. An SK rise is a 0->1 transition of synchronised SK. Every frame action below occurs on that detected edge.
- Reset: DO=0, DO_OE=0, BUSY=0, write-enable (WEN)=0, state IDLE. Memory words 0..DEPTH-2 = all ones, word DEPTH-1 = INIT_ID.
- States: IDLE, START, OPC, ADDR, RDATA, WDATA, WAIT_CS, BUSY.
- IDLE -> START on CS high. In START, DI=0 bits are ignored (leading zeros allowed). The first DI=1 -> OPC.
- OPC takes 2 bits, MSB first, then ADDR takes ADDR_W bits, MSB first.
- Opcodes:
  - 10 READ
  - 01 WRITE
  - 11 ERASE
  - 00 extended, decoded on the 2 address MSBs: 11 = EWEN, 00 = EWDS, others ignored.
- READ: on the edge that captures the last address bit, DO_OE=1 and DO=0 (dummy bit). Each following edge shifts out the word MSB first. After bit 0, the address increments mod DEPTH (DEPTH-1 wraps to 0) and output continues seamlessly. Output stops only when CS falls.
- WRITE: DATA_W bits captured into the shift register -> WAIT_CS. Extra SK edges in WAIT_CS are ignored.
- Commit on CS fall in WAIT_CS, only if WEN=1 and PE=1; otherwise no change.
  - WRITE stores the shifted word; ERASE stores all ones.
  - Memory updates on the commit cycle. BUSY=1 for exactly WRITE_CYCLES CLKs, then -> IDLE.
- EWEN/EWDS set/clear WEN on the last address edge; no DO activity.
- During BUSY with CS high: DO_OE=1, DO=0. After BUSY ends with CS still high: DO=1 (ready) until CS falls. All frames are ignored during BUSY.
- CS fall in any state other than WAIT_CS or BUSY aborts: DO_OE=0, -> IDLE, memory unchanged. A partial WRITE never commits.
- CS fall sets DO_OE=0 within 3 CLK.
- RST_N assertion mid-write or mid-busy restores full reset contents; no partial commit.

Optional Feature:
MICROWIRE_PROTECT_EN: adds a protect register PROT (ADDR_W bits), reset value DEPTH-1.
- WRITE/ERASE to address >= PROT are blocked silently; no busy period.
- With PRE=1 the frame targets PROT:
  - READ returns PROT zero-extended to DATA_W.
  - WRITE sets PROT from the address field, under WEN and PE, with normal busy.
- Without the macro: PRE is ignored, PROT logic is absent, all addresses are writable.

Test Plan:
1. Reset, then READ addr 15 with 2 leading zeros -> DO = dummy 0, then 16'hA5C3 MSB first.
2. READ addr 14, clock 48 data bits -> words 14, 15, then 0 (wrap), all 16'hFFFF except word 15 = 16'hA5C3.
3. WRITE 16'h1234 to addr 3 without EWEN -> READ addr 3 returns 16'hFFFF. Then EWEN, PE=1, same WRITE -> BUSY high 64 CLK, status DO 0 then 1, READ returns 16'h1234.
4. WRITE with CS dropped after 9 data bits -> no BUSY, addr 3 unchanged; a subsequent ERASE addr 3 -> 16'hFFFF.
5. RST_N pulse during BUSY of a WRITE to addr 5 -> BUSY=0, WEN=0, addr 5 = 16'hFFFF.
6. MICROWIRE_PROTECT_EN: EWEN, WRITE addr 15 -> blocked, still 16'hA5C3. PRE=1 WRITE PROT=8, then WRITE addr 9 blocked and addr 7 succeeds.
